// File: rtl/forward_scoreboard_pkg.sv
// Shared defaults, unified register encodings and slot layout for the forwarding scoreboard.
package forward_scoreboard_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int REG_ADDR_W_DEF = 4;

    // One flat register namespace, so special registers need no separate forwarding path.
    typedef enum logic [REG_ADDR_W_DEF-1:0] {
        REG_R0 = 4'd0,
        REG_R1 = 4'd1,
        REG_R2 = 4'd2,
        REG_R3 = 4'd3,
        REG_R4 = 4'd4,
        REG_R5 = 4'd5,
        REG_R6 = 4'd6,
        REG_R7 = 4'd7,
        REG_SP = 4'd8,
        REG_T  = 4'd9,
        REG_IH = 4'd10
    } reg_e;

    localparam logic FORWARD_ENABLE  = 1'b1;
    localparam logic FORWARD_DISABLE = 1'b0;

    // Field order of one in-flight slot at the default widths.
    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_W_DEF-1:0] addr;
        logic                      ready;
        logic [DATA_W_DEF-1:0]     data;
    } slot_t;

    localparam int SLOT_W = $bits(slot_t);

endpackage

// File: rtl/forward_scoreboard_if.sv
// Decode/pipeline side bundle of the forwarding scoreboard.
interface forward_scoreboard_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 3,
    parameter int NUM_RD     = 2
) ();
    logic                         pipe_advance;
    logic                         flush;
    logic                         issue_valid;
    logic                         issue_wr_en;
    logic [REG_ADDR_W-1:0]        issue_wr_addr;
    logic [DEPTH-1:0]             stage_res_valid;
    logic [DEPTH*DATA_W-1:0]      stage_res_data;
    logic [NUM_RD-1:0]            rd_en;
    logic [NUM_RD*REG_ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0]     fwd_data;
    logic [NUM_RD-1:0]            fwd_en;
    logic                         stall_out;
    logic [15:0]                  stall_cnt;

    modport master (
        output pipe_advance, flush, issue_valid, issue_wr_en, issue_wr_addr,
               stage_res_valid, stage_res_data, rd_en, rd_addr,
        input  fwd_data, fwd_en, stall_out, stall_cnt
    );

    modport slave (
        input  pipe_advance, flush, issue_valid, issue_wr_en, issue_wr_addr,
               stage_res_valid, stage_res_data, rd_en, rd_addr,
        output fwd_data, fwd_en, stall_out, stall_cnt
    );
endinterface

// File: rtl/forward_scoreboard_lookup.sv
// Youngest-match search over the in-flight slots for one decode read port.
module forward_lookup
    import forward_scoreboard_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 3
) (
    input  logic [DEPTH-1:0]                 slot_valid_i,
    input  logic [DEPTH-1:0]                 slot_ready_i,
    input  logic [DEPTH-1:0][REG_ADDR_W-1:0] slot_addr_i,
    input  logic [DEPTH-1:0][DATA_W-1:0]     slot_data_i,
    input  logic [DEPTH-1:0]                 res_valid_i,
    input  logic [DEPTH-1:0][DATA_W-1:0]     res_data_i,
    input  logic                             rd_en_i,
    input  logic [REG_ADDR_W-1:0]            rd_addr_i,
    output logic                             fwd_en_o,
    output logic [DATA_W-1:0]                fwd_data_o,
    output logic                             hazard_o
);
    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        fwd_en_o   = FORWARD_DISABLE;
        fwd_data_o = '0;
        hazard_o   = 1'b0;
        if (rd_en_i) begin
            for (int s = DEPTH - 1; s >= 0; s--) begin
                if (slot_valid_i[s] && (slot_addr_i[s] == rd_addr_i)) begin
                    if (slot_ready_i[s]) begin
                        fwd_en_o   = FORWARD_ENABLE;
                        fwd_data_o = slot_data_i[s];
                        hazard_o   = 1'b0;
                    end else if (res_valid_i[s]) begin
                        fwd_en_o   = FORWARD_ENABLE;
                        fwd_data_o = res_data_i[s];
                        hazard_o   = 1'b0;
                    end else begin
                        fwd_en_o   = FORWARD_DISABLE;
                        fwd_data_o = '0;
                        hazard_o   = 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/forward_scoreboard.sv
// Shift-register scoreboard of in-flight register writes with operand forwarding and stall.
module forward_scoreboard
    import forward_scoreboard_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DEPTH      = 3,
    parameter int NUM_RD     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    forward_scoreboard_if.slave  bus
);
    logic [DEPTH-1:0]                 valid_q, valid_d;
    logic [DEPTH-1:0]                 ready_q, ready_d;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] addr_q,  addr_d;
    logic [DEPTH-1:0][DATA_W-1:0]     data_q,  data_d;
    logic [15:0]                      stall_cnt_q, stall_cnt_d;

    logic [DEPTH-1:0][DATA_W-1:0]      res_data;
    logic [NUM_RD-1:0][REG_ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0]     fwd_data;
    logic [NUM_RD-1:0]                 fwd_en;
    logic [NUM_RD-1:0]                 hazard;
    logic [DEPTH-1:0]                  cap_ready;
    logic [DEPTH-1:0][DATA_W-1:0]      cap_data;
    logic                              stall;
    logic                              issue_ok;

    assign res_data = bus.stage_res_data;
    assign rd_addr  = bus.rd_addr;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        forward_lookup #(
            .DATA_W     (DATA_W),
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH)
        ) u_lookup (
            .slot_valid_i (valid_q),
            .slot_ready_i (ready_q),
            .slot_addr_i  (addr_q),
            .slot_data_i  (data_q),
            .res_valid_i  (bus.stage_res_valid),
            .res_data_i   (res_data),
            .rd_en_i      (bus.rd_en[p]),
            .rd_addr_i    (rd_addr[p]),
            .fwd_en_o     (fwd_en[p]),
            .fwd_data_o   (fwd_data[p]),
            .hazard_o     (hazard[p])
        );
    end

    assign stall         = bus.issue_valid && (|hazard);
    assign issue_ok      = bus.issue_valid && bus.issue_wr_en && !stall && !bus.flush;
    assign bus.fwd_data  = fwd_data;
    assign bus.fwd_en    = fwd_en;
    assign bus.stall_out = stall;
    assign bus.stall_cnt = stall_cnt_q;

    // Each slot's view after this cycle's result capture, before any shift.
    always_comb begin
        cap_ready = ready_q;
        cap_data  = data_q;
        for (int s = 0; s < DEPTH; s++) begin
            if (valid_q[s] && !ready_q[s] && bus.stage_res_valid[s]) begin
                cap_ready[s] = 1'b1;
                cap_data[s]  = res_data[s];
            end
        end
    end

    always_comb begin
        valid_d     = valid_q;
        ready_d     = cap_ready;
        addr_d      = addr_q;
        data_d      = cap_data;
        stall_cnt_d = stall_cnt_q;
        if (bus.pipe_advance) begin
            for (int i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                ready_d[i] = cap_ready[i-1];
                addr_d[i]  = addr_q[i-1];
                data_d[i]  = cap_data[i-1];
            end
            valid_d[0] = issue_ok;
            ready_d[0] = 1'b0;
            addr_d[0]  = issue_ok ? bus.issue_wr_addr : '0;
            data_d[0]  = '0;
            if (stall && (stall_cnt_q != 16'hFFFF))
                stall_cnt_d = stall_cnt_q + 16'd1;
        end else if (bus.flush) begin
            valid_d[0] = 1'b0;
            ready_d[0] = 1'b0;
            addr_d[0]  = '0;
            data_d[0]  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q     <= '0;
            ready_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed and randomized checks of forward_scoreboard against an in-bench pipeline model.
module tb_forward_scoreboard;
    import forward_scoreboard_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int D  = 3;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    forward_scoreboard_if #(.DATA_W(DW), .REG_ADDR_W(AW), .DEPTH(D), .NUM_RD(NR)) bus ();

    forward_scoreboard #(.DATA_W(DW), .REG_ADDR_W(AW), .DEPTH(D), .NUM_RD(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Model: each pipeline stage holds at most one pending write with its known result.
    typedef struct {
        bit          v;
        bit          r;
        int unsigned a;
        int unsigned d;
    } ms_t;

    ms_t         m[D];
    int unsigned m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int unsigned res_of(int s);
        logic [D*DW-1:0] all;
        all = bus.stage_res_data;
        return int'(all[s*DW +: DW]);
    endfunction

    function automatic void m_lookup(input int p, output bit en, output int unsigned data,
                                     output bit haz);
        bit          found;
        int unsigned ra;
        logic [NR*AW-1:0] addrs;
        addrs = bus.rd_addr;
        ra    = int'(addrs[p*AW +: AW]);
        en    = 0;
        data  = 0;
        haz   = 0;
        found = 0;
        if (bus.rd_en[p]) begin
            for (int s = 0; s < D; s++) begin
                if (!found && m[s].v && m[s].a == ra) begin
                    found = 1;
                    if (m[s].r) begin
                        en = 1; data = m[s].d;
                    end else if (bus.stage_res_valid[s]) begin
                        en = 1; data = res_of(s);
                    end else begin
                        haz = 1;
                    end
                end
            end
        end
    endfunction

    function automatic bit m_stall();
        bit          any, en, haz;
        int unsigned data;
        any = 0;
        for (int p = 0; p < NR; p++) begin
            m_lookup(p, en, data, haz);
            any |= haz;
        end
        return any && bus.issue_valid;
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < D; s++) m[s] = '{0, 0, 0, 0};
        m_cnt = 0;
    endfunction

    function automatic void m_update(input bit stall);
        if (!rst) begin
            m_clear();
            return;
        end
        for (int s = 0; s < D; s++)
            if (m[s].v && !m[s].r && bus.stage_res_valid[s]) begin
                m[s].r = 1;
                m[s].d = res_of(s);
            end
        if (bus.pipe_advance) begin
            for (int i = D - 1; i > 0; i--) m[i] = m[i-1];
            if (bus.issue_valid && bus.issue_wr_en && !stall && !bus.flush)
                m[0] = '{1, 0, int'(bus.issue_wr_addr), 0};
            else
                m[0] = '{0, 0, 0, 0};
            if (stall && m_cnt < 32'hFFFF) m_cnt++;
        end else if (bus.flush) begin
            m[0] = '{0, 0, 0, 0};
        end
    endfunction

    // Compare all outputs against the model, then clock one edge.
    task automatic step();
        bit          en, haz, stall;
        int unsigned data;
        logic [NR*DW-1:0] fd;
        #1;
        fd = bus.fwd_data;
        for (int p = 0; p < NR; p++) begin
            m_lookup(p, en, data, haz);
            chk($sformatf("p%0d_fwd_en", p), 32'(bus.fwd_en[p]), 32'(en));
            chk($sformatf("p%0d_fwd_data", p), 32'(fd[p*DW +: DW]), data);
        end
        stall = m_stall();
        chk("stall_out", 32'(bus.stall_out), 32'(stall));
        chk("stall_cnt", 32'(bus.stall_cnt), m_cnt);
        @(posedge clk);
        m_update(stall);
        #1;
    endtask

    task automatic idle();
        bus.pipe_advance    = 1'b0;
        bus.flush           = 1'b0;
        bus.issue_valid     = 1'b0;
        bus.issue_wr_en     = 1'b0;
        bus.issue_wr_addr   = '0;
        bus.stage_res_valid = '0;
        bus.stage_res_data  = '0;
        bus.rd_en           = '0;
        bus.rd_addr         = '0;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        idle();
        bus.pipe_advance  = 1'b1;
        bus.issue_valid   = 1'b1;
        bus.issue_wr_en   = 1'b1;
        bus.issue_wr_addr = a;
        step();
    endtask

    task automatic read0(input logic [AW-1:0] a);
        bus.issue_valid   = 1'b1;
        bus.rd_en[0]      = 1'b1;
        bus.rd_addr[AW-1:0] = a;
    endtask

    task automatic set_res(input int s, input logic [DW-1:0] v);
        bus.stage_res_valid[s]      = 1'b1;
        bus.stage_res_data[s*DW +: DW] = v;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        logic [63:0] r64;
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_clear();
        rst = 1'b1;

        // Reset state
        #1;
        chk("rst_fwd_en", 32'(bus.fwd_en), 0);
        chk("rst_fwd_data", 32'(bus.fwd_data), 0);
        chk("rst_stall", 32'(bus.stall_out), 0);
        step();

        // ALU back-to-back
        issue(REG_R1);
        idle(); bus.pipe_advance = 1'b1; read0(REG_R1); set_res(0, 16'h1234);
        #1;
        chk("alu_fwd_en", 32'(bus.fwd_en[0]), 1);
        chk("alu_fwd_data", 32'(bus.fwd_data[DW-1:0]), 32'h1234);
        chk("alu_stall", 32'(bus.stall_out), 0);
        step();

        // Load-use
        do_reset();
        issue(REG_R2);
        idle(); bus.pipe_advance = 1'b1; read0(REG_R2);
        #1;
        chk("lu_stall", 32'(bus.stall_out), 1);
        chk("lu_fwd_en", 32'(bus.fwd_en[0]), 0);
        step();
        set_res(1, 16'hBEEF);
        #1;
        chk("lu_bypass_en", 32'(bus.fwd_en[0]), 1);
        chk("lu_bypass_data", 32'(bus.fwd_data[DW-1:0]), 32'hBEEF);
        chk("lu_stall_clear", 32'(bus.stall_out), 0);
        chk("lu_stall_cnt", 32'(bus.stall_cnt), 1);
        step();

        // Youngest wins: R3 ready in slot 2 (0x0001) and slot 0 (0x0002)
        do_reset();
        issue(REG_R3);
        idle(); bus.pipe_advance = 1'b1; set_res(0, 16'h0001); step();
        issue(REG_R3);
        idle(); set_res(0, 16'h0002); step();
        idle(); read0(REG_R3);
        #1;
        chk("young_fwd_en", 32'(bus.fwd_en[0]), 1);
        chk("young_fwd_data", 32'(bus.fwd_data[DW-1:0]), 32'h0002);
        step();

        // rd_en gating on the same state
        idle(); bus.issue_valid = 1'b1; bus.rd_addr[AW-1:0] = REG_R3;
        #1;
        chk("gate_fwd_en", 32'(bus.fwd_en[0]), 0);
        chk("gate_fwd_data", 32'(bus.fwd_data[DW-1:0]), 0);
        chk("gate_stall", 32'(bus.stall_out), 0);
        step();

        // Flush without advance kills slot 0 and drops the issue
        do_reset();
        issue(REG_R4);
        idle(); bus.flush = 1'b1; bus.issue_valid = 1'b1; bus.issue_wr_en = 1'b1;
        bus.issue_wr_addr = REG_R5; step();
        idle(); read0(REG_R4); bus.rd_en[1] = 1'b1; bus.rd_addr[2*AW-1:AW] = REG_R5;
        #1;
        chk("flush_fwd_en", 32'(bus.fwd_en), 0);
        chk("flush_stall", 32'(bus.stall_out), 0);
        step();

        // Reset mid-operation with all slots valid and stall_cnt=5
        do_reset();
        issue(REG_R6);
        repeat (3) begin idle(); bus.pipe_advance = 1'b1; read0(REG_R6); step(); end
        issue(REG_R6);
        repeat (2) begin idle(); bus.pipe_advance = 1'b1; read0(REG_R6); step(); end
        issue(REG_R0); issue(REG_R1); issue(REG_R2);
        idle();
        #1;
        chk("mid_cnt_before", 32'(bus.stall_cnt), 5);
        do_reset();
        idle(); bus.issue_valid = 1'b1; bus.rd_en = '1;
        bus.rd_addr = {4'(REG_R1), 4'(REG_R0)};
        #1;
        chk("mid_fwd_en", 32'(bus.fwd_en), 0);
        chk("mid_stall", 32'(bus.stall_out), 0);
        chk("mid_cnt", 32'(bus.stall_cnt), 0);
        step();

        // Randomized traffic over a small register subset to force matches
        for (int c = 0; c < 600; c++) begin
            bus.pipe_advance    = ($urandom_range(0, 3) != 0);
            bus.flush           = ($urandom_range(0, 15) == 0);
            bus.issue_valid     = ($urandom_range(0, 3) != 0);
            bus.issue_wr_en     = 1'($urandom_range(0, 1));
            bus.issue_wr_addr   = AW'($urandom_range(0, 3));
            bus.stage_res_valid = D'($urandom_range(0, (1 << D) - 1));
            r64 = {$urandom(), $urandom()};
            bus.stage_res_data  = r64[D*DW-1:0];
            bus.rd_en           = NR'($urandom_range(0, (1 << NR) - 1));
            for (int p = 0; p < NR; p++)
                bus.rd_addr[p*AW +: AW] = AW'($urandom_range(0, 3));
            rst = ($urandom_range(0, 99) != 0);
            step();
        end
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/forward_scoreboard.md
Name: forward_scoreboard

Overview:
- Parametrised successor to the fixed two-stage EX/MEM forwarding mux.
- Keeps its own shift-register scoreboard of in-flight register writes, DEPTH stages deep, covering EX through the last stage before writeback.
- Latches each result when it becomes available and forwards the youngest matching value to NUM_RD decode read ports.
- Raises a stall for load-use style hazards, where the producer's result is not yet available.
- Unified register address space: R0-R7 and SP/T/IH each have their own encoding, so no per-register-class special cases are needed.

Parameters:
DATA_W, 16, datapath width
REG_ADDR_W, 4, unified register address width
DEPTH, 3, in-flight stages tracked (slot 0 = EX, slot DEPTH-1 = last before writeback)
NUM_RD, 2, decode read ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active low
pipe_advance  in  1  pipeline registers update this cycle
flush  in  1  kill slot 0 and any incoming issue
issue_valid  in  1  decode holds a valid instruction
issue_wr_en  in  1  issued instruction writes a register
issue_wr_addr  in  REG_ADDR_W  destination register
stage_res_valid  in  DEPTH  result of instruction in stage s is available this cycle
stage_res_data  in  DEPTH*DATA_W  per-stage result; stage s occupies bits [s*DATA_W +: DATA_W]
rd_en  in  NUM_RD  read port p actually consumes a register (operand mux selects a register)
rd_addr  in  NUM_RD*REG_ADDR_W  read addresses
fwd_data  out  NUM_RD*DATA_W  forwarded operand per port
fwd_en  out  NUM_RD  forward valid per port
stall_out  out  1  hold decode/fetch; insert bubble
stall_cnt  out  16  saturating count of stall cycles

Behaviour:
- Reset: when rst=0 at a clk edge, all slots are cleared (valid=0, ready=0, data=0) and stall_cnt=0.
- Outputs are combinational from state, so directly after reset fwd_en=0, fwd_data=0 and stall_out=0.
- Slot contents: valid, addr, ready, data[DATA_W].
- Capture: every cycle, for each slot s with valid && !ready && stage_res_valid[s]:
  - the slot takes ready=1 and data=stage_res_data[s];
  - if pipe_advance is high in the same cycle, the captured value moves into slot s+1.
- Advance (pipe_advance=1):
  - slot[i] <= slot[i-1] with that cycle's capture merged in;
  - slot[DEPTH-1] retires and is dropped;
  - slot[0] <= {issue_wr_addr, valid=1, ready=0} only if issue_valid && issue_wr_en && !stall_out && !flush; otherwise slot[0] becomes a bubble.
- No advance: slots hold, apart from captures.
- Flush:
  - invalidates slot 0 at the edge and blocks issue;
  - if pipe_advance is also high, slot 0 becomes a bubble and the old slot 0 advances into slot 1, i.e. it is not killed.
- Lookup, per port p with rd_en[p]=1:
  - scan slots 0..DEPTH-1; the youngest valid slot with addr==rd_addr[p] wins;
  - winner ready: fwd_en=1, fwd_data=slot data;
  - winner not ready but stage_res_valid[s]: fwd_en=1, fwd_data=stage_res_data[s] (same-cycle bypass);
  - otherwise: fwd_en=0 and hazard[p]=1;
  - no match or rd_en[p]=0: fwd_en=0, fwd_data=0, hazard=0.
- stall_out = OR of hazard[p] over all ports, gated by issue_valid.
- stall_cnt increments at each edge where stall_out=1 and pipe_advance=1, and saturates at 0xFFFF.
- Simultaneous events:
  - stall with advance: a bubble enters slot 0 and older slots keep moving, so the load reaches a stage where its result is valid;
  - flush and stall together: flush wins, issue is dropped, and the stall clears next cycle once the decode contents change.

Decomposition:
- Shared package/define file: DATA_W and REG_ADDR_W defaults, the unified register encodings (R0-R7, SP, T, IH), FORWARD_ENABLE/DISABLE, and the slot field layout.
- One sub-module, forward_lookup: a purely combinational youngest-match priority search for a single port, instantiated NUM_RD times.

Test Plan:
1. ALU back-to-back:
   - stimulus: issue write R1; next cycle stage_res_valid[0]=1 with data 0x1234; port0 reads R1;
   - required: fwd_en[0]=1, fwd_data=0x1234, stall_out=0.
2. Load-use:
   - stimulus: issue write R2 as a load; result only at stage 1; next instruction reads R2;
   - required: stall_out=1 for one advance, bubble in slot 0, then fwd_data=0xBEEF from the stage-1 bypass and stall_cnt=1.
3. Youngest wins:
   - stimulus: R3 written in slot 2 (0x0001 ready) and slot 0 (0x0002 ready);
   - required: fwd_data=0x0002.
4. rd_en gating:
   - stimulus: matching ready slot present, rd_en=0;
   - required: fwd_en=0, fwd_data=0, stall_out=0.
5. Flush:
   - stimulus: flush with pipe_advance=0 while slot 0 holds R4;
   - required: next cycle a read of R4 gives fwd_en=0, and the issue in that cycle is not recorded.
6. Reset mid-operation:
   - stimulus: all slots valid and stall_cnt=5, then rst=0 for one edge;
   - required: all lookups give fwd_en=0, stall_out=0, stall_cnt=0.
